mem_stage_dcache: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache forming the memory stage of the five-stage RISC-V pipeline. It consumes the EX/MEM pipeline register outputs (ALU result as address, store data, memory read/write enables, func3) and returns load data, sign- or zero-extended, to the MEM/WB register. Misses and all stores go to backing memory over a req/ack handshake while the pipeline is stalled.

---
 rtl/mem_stage_dcache.sv | 243 ++++++++++++++++++++++++
 tb/tb_mem_stage_dcache.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_dcache.sv
// mem_stage_dcache: direct-mapped, write-through, no-write-allocate data cache
// for the memory stage of a five-stage RISC-V pipeline. Load hits return data
// combinationally; load misses and all stores stall the pipeline while a
// req/ack transfer to backing memory completes.
// Optional feature macro: CACHE_STATS_EN adds 32-bit hit/miss counters.
module mem_stage_dcache #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int SETS          = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0]    write_data_in,
  input  logic                     read_en_in,
  input  logic                     write_en_in,
  input  logic [2:0]               func_3_in,
  output logic [DATA_WIDTH-1:0]    read_data_out,
  output logic                     stall_out,
  output logic                     mem_req_out,
  output logic                     mem_we_out,
  output logic [ADDRESS_WIDTH-1:0] mem_addr_out,
  output logic [DATA_WIDTH-1:0]    mem_wdata_out,
  output logic [3:0]               mem_wstrb_out,
  input  logic [DATA_WIDTH-1:0]    mem_rdata_in,
  input  logic                     mem_ack_in
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]              hit_count_out,
  output logic [31:0]              miss_count_out
`endif
);

  localparam int INDEX_BITS = $clog2(SETS);
  localparam int TAG_BITS   = ADDRESS_WIDTH - INDEX_BITS - 2;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  state_t                   state_q, state_d;
  logic [SETS-1:0]          valid_q;
  logic [TAG_BITS-1:0]      tag_q  [SETS];
  logic [DATA_WIDTH-1:0]    data_q [SETS];

  logic                     mem_req_q, mem_req_d;
  logic                     mem_we_q, mem_we_d;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
  logic [3:0]               mem_wstrb_q, mem_wstrb_d;

  logic [INDEX_BITS-1:0]    idx;
  logic [TAG_BITS-1:0]      tag;
  logic [INDEX_BITS-1:0]    fill_idx;
  logic [TAG_BITS-1:0]      fill_tag;
  logic                     hit;
  logic                     ack;
  logic                     read_hit;
  logic                     fill_en;
  logic                     wr_hit_en;
  logic [DATA_WIDTH-1:0]    st_data;
  logic [3:0]               st_strb;

  // Lane extraction and sign/zero extension for loads.
  function automatic logic [DATA_WIDTH-1:0] load_extend(
    input logic [DATA_WIDTH-1:0] word,
    input logic [2:0]            f3,
    input logic [1:0]            off
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  load_extend = {{(DATA_WIDTH-8){b[7]}}, b};
      3'b001:  load_extend = {{(DATA_WIDTH-16){h[15]}}, h};
      3'b100:  load_extend = {{(DATA_WIDTH-8){1'b0}}, b};
      3'b101:  load_extend = {{(DATA_WIDTH-16){1'b0}}, h};
      default: load_extend = word;
    endcase
  endfunction

  // Byte strobes for a store of the given size at the given offset.
  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000:  store_strb = 4'b0001 << off;
      3'b001:  store_strb = off[1] ? 4'b1100 : 4'b0011;
      default: store_strb = 4'b1111;
    endcase
  endfunction

  // Store data moved onto its byte lanes; unused lanes are zero.
  function automatic logic [DATA_WIDTH-1:0] store_data(
    input logic [DATA_WIDTH-1:0] wd,
    input logic [2:0]            f3,
    input logic [1:0]            off
  );
    case (f3)
      3'b000:  store_data = DATA_WIDTH'(wd[7:0]) << {off, 3'b000};
      3'b001:  store_data = DATA_WIDTH'(wd[15:0]) << {off[1], 4'b0000};
      default: store_data = wd;
    endcase
  endfunction

  // Merge strobed bytes of a store into an existing line.
  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [3:0]            strb
  );
    merge_bytes = old_w;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) merge_bytes[8*i +: 8] = new_w[8*i +: 8];
    end
  endfunction

  assign idx      = addr_in[INDEX_BITS+1:2];
  assign tag      = addr_in[ADDRESS_WIDTH-1:INDEX_BITS+2];
  assign fill_idx = mem_addr_q[INDEX_BITS+1:2];
  assign fill_tag = mem_addr_q[ADDRESS_WIDTH-1:INDEX_BITS+2];
  assign hit      = valid_q[idx] && (tag_q[idx] == tag);
  assign ack      = mem_ack_in && mem_req_q;
  assign st_strb  = store_strb(func_3_in, addr_in[1:0]);
  assign st_data  = store_data(write_data_in, func_3_in, addr_in[1:0]);

  assign mem_req_out   = mem_req_q;
  assign mem_we_out    = mem_we_q;
  assign mem_addr_out  = mem_addr_q;
  assign mem_wdata_out = mem_wdata_q;
  assign mem_wstrb_out = mem_wstrb_q;

  // Next-state, stall, load data and request-field decisions.
  always_comb begin
    state_d       = state_q;
    stall_out     = 1'b0;
    read_hit      = 1'b0;
    fill_en       = 1'b0;
    wr_hit_en     = 1'b0;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_wstrb_d   = mem_wstrb_q;
    read_data_out = '0;
    case (state_q)
      IDLE: begin
        if (write_en_in) begin
          stall_out   = 1'b1;
          wr_hit_en   = hit;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = {addr_in[ADDRESS_WIDTH-1:2], 2'b00};
          mem_wdata_d = st_data;
          mem_wstrb_d = st_strb;
          state_d     = WR_WAIT;
        end else if (read_en_in) begin
          if (hit) begin
            read_hit      = 1'b1;
            read_data_out = load_extend(data_q[idx], func_3_in, addr_in[1:0]);
          end else begin
            stall_out   = 1'b1;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = {addr_in[ADDRESS_WIDTH-1:2], 2'b00};
            mem_wdata_d = '0;
            mem_wstrb_d = 4'b0000;
            state_d     = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        stall_out = 1'b1;
        if (ack) begin
          fill_en   = 1'b1;
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      WR_WAIT: begin
        stall_out = !ack;
        if (ack) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, valid bits and the registered memory request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= 4'b0000;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      if (fill_en) valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag and data arrays: refill on read ack, byte merge on store hit.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      data_q[fill_idx] <= mem_rdata_in;
      tag_q[fill_idx]  <= fill_tag;
    end else if (wr_hit_en) begin
      data_q[idx] <= merge_bytes(data_q[idx], st_data, st_strb);
    end
  end

`ifdef CACHE_STATS_EN
  logic        refill_q;
  logic        read_miss;
  logic [31:0] hit_cnt_q, miss_cnt_q;

  assign read_miss      = (state_q == IDLE) && read_en_in && !write_en_in && !hit;
  assign hit_count_out  = hit_cnt_q;
  assign miss_count_out = miss_cnt_q;

  // Count first-time read hits and read misses; the hit right after a refill
  // belongs to the miss that caused it and is not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refill_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      refill_q <= fill_en;
      if (read_hit && !refill_q) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (read_miss) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_stage_dcache.sv
// Bench for mem_stage_dcache: directed scenarios plus random loads/stores,
// checked against a word-level memory model and a tag/valid cache model.
module tb_mem_stage_dcache;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SETS = 256;
  localparam int TAGB = AW - 8 - 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] addr_in;
  logic [DW-1:0] write_data_in;
  logic          read_en_in, write_en_in;
  logic [2:0]    func_3_in;
  logic [DW-1:0] read_data_out;
  logic          stall_out, mem_req_out, mem_we_out;
  logic [AW-1:0] mem_addr_out;
  logic [DW-1:0] mem_wdata_out;
  logic [3:0]    mem_wstrb_out;
  logic [DW-1:0] mem_rdata_in;
  logic          mem_ack_in;
`ifdef CACHE_STATS_EN
  logic [31:0]   hit_count_out, miss_count_out;
  int unsigned   m_hits, m_misses;
`endif

  mem_stage_dcache #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .SETS(SETS)) dut (
    .clk(clk), .rst(rst), .addr_in(addr_in), .write_data_in(write_data_in),
    .read_en_in(read_en_in), .write_en_in(write_en_in), .func_3_in(func_3_in),
    .read_data_out(read_data_out), .stall_out(stall_out), .mem_req_out(mem_req_out),
    .mem_we_out(mem_we_out), .mem_addr_out(mem_addr_out), .mem_wdata_out(mem_wdata_out),
    .mem_wstrb_out(mem_wstrb_out), .mem_rdata_in(mem_rdata_in), .mem_ack_in(mem_ack_in)
`ifdef CACHE_STATS_EN
    , .hit_count_out(hit_count_out), .miss_count_out(miss_count_out)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mem [logic [31:0]];
  bit          mv [SETS];
  logic [TAGB-1:0] mt [SETS];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] wa);
    if (mem.exists(wa)) return mem[wa];
    return wa * 32'h9E37_79B1 + 32'h1234_5671;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] v;
    case (f3)
      3'd0, 3'd4: begin
        v = (w >> (8 * off)) & 32'hFF;
        if (f3 == 3'd0 && v >= 32'd128) v = v + 32'hFFFF_FF00;
      end
      3'd1, 3'd5: begin
        v = (w >> (16 * off[1])) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  // One pipeline operation: drive it, play backing memory with 'lat' wait
  // cycles before ack, and compare stall length, load data and request fields.
  task automatic access(input bit we, input bit re, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int lat, output logic [31:0] rdata);
    logic [31:0] wa, exp_data, exp_wd, nw;
    logic [3:0]  exp_strb;
    logic [TAGB-1:0] tg;
    int idx, exp_stall, stalls, wcnt;
    bit hit, acked, done;
    wa  = {a[31:2], 2'b00};
    idx = int'(a[9:2]);
    tg  = a[31:10];
    hit = mv[idx] && (mt[idx] == tg);
    exp_data = 32'd0; exp_wd = 32'd0; exp_strb = 4'd0; exp_stall = 0;
    if (we) begin
      exp_stall = lat + 1;
      case (f3)
        3'd0:    begin exp_strb = 4'd1 << a[1:0]; exp_wd = (wd & 32'hFF) << (8 * a[1:0]); end
        3'd1:    begin exp_strb = a[1] ? 4'hC : 4'h3; exp_wd = (wd & 32'hFFFF) << (16 * a[1]); end
        default: begin exp_strb = 4'hF; exp_wd = wd; end
      endcase
    end else if (re) begin
      exp_stall = hit ? 0 : lat + 2;
      exp_data  = ref_load(mem_rd(wa), f3, a[1:0]);
    end
    @(posedge clk); #1;
    write_en_in = we; read_en_in = re; func_3_in = f3; addr_in = a; write_data_in = wd;
    mem_ack_in = 1'b0;
    stalls = 0; wcnt = 0; acked = 0; done = 0; rdata = 32'd0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (mem_req_out && !acked) begin
        if (wcnt == lat) begin
          acked = 1;
          check_eq("req_addr", mem_addr_out, wa);
          check_eq("req_we", {31'd0, mem_we_out}, {31'd0, we});
          if (we) begin
            check_eq("req_wstrb", {28'd0, mem_wstrb_out}, {28'd0, exp_strb});
            check_eq("req_wdata", mem_wdata_out, exp_wd);
            nw = mem_rd(wa);
            for (int b = 0; b < 4; b++) if (exp_strb[b]) nw[8*b +: 8] = exp_wd[8*b +: 8];
            mem[wa] = nw;
          end else begin
            mem_rdata_in = mem_rd(wa);
          end
          mem_ack_in = 1'b1;
        end else begin
          wcnt++;
        end
      end
      #1;
      if (!stall_out) begin
        done = 1;
        rdata = read_data_out;
        break;
      end
      stalls++;
      @(posedge clk); #1;
      mem_ack_in = 1'b0;
    end
    if (!done) check_eq("timeout_stall", {31'd0, stall_out}, 32'd0);
    check_eq(we ? "st_stall_len" : (re ? "ld_stall_len" : "idle_stall_len"), stalls, exp_stall);
    check_eq(re && !we ? "ld_data" : "no_ld_data", rdata, exp_data);
    if (!we) check_eq("req_idle", {31'd0, mem_req_out}, 32'd0);
    if (re && !we) begin
`ifdef CACHE_STATS_EN
      if (hit) m_hits++; else m_misses++;
`endif
      mv[idx] = 1'b1;
      mt[idx] = tg;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_stall"}, {31'd0, stall_out}, 32'd0);
    check_eq({tag, "_rdata"}, read_data_out, 32'd0);
    check_eq({tag, "_req"}, {31'd0, mem_req_out}, 32'd0);
    check_eq({tag, "_we"}, {31'd0, mem_we_out}, 32'd0);
    check_eq({tag, "_addr"}, mem_addr_out, 32'd0);
    check_eq({tag, "_wdata"}, mem_wdata_out, 32'd0);
    check_eq({tag, "_wstrb"}, {28'd0, mem_wstrb_out}, 32'd0);
`ifdef CACHE_STATS_EN
    check_eq({tag, "_hits"}, hit_count_out, 32'd0);
    check_eq({tag, "_misses"}, miss_count_out, 32'd0);
`endif
  endtask

  logic [2:0] ld_f3 [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

  initial begin
    logic [31:0] r, a;
    int op;
    rst = 1'b1; addr_in = '0; write_data_in = '0; read_en_in = 1'b0; write_en_in = 1'b0;
    func_3_in = 3'd0; mem_rdata_in = '0; mem_ack_in = 1'b0;
    for (int i = 0; i < SETS; i++) mv[i] = 1'b0;
`ifdef CACHE_STATS_EN
    m_hits = 0; m_misses = 0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_rst");

    mem[32'h100] = 32'hDEAD_BEEF;
    access(0, 1, 3'd2, 32'h100, 0, 2, r); check_eq("tp_lw_miss", r, 32'hDEAD_BEEF);
    access(0, 1, 3'd2, 32'h100, 0, 0, r); check_eq("tp_lw_hit", r, 32'hDEAD_BEEF);
    access(0, 1, 3'd0, 32'h103, 0, 0, r); check_eq("tp_lb", r, 32'hFFFF_FFDE);
    access(0, 1, 3'd4, 32'h103, 0, 0, r); check_eq("tp_lbu", r, 32'h0000_00DE);
    access(0, 1, 3'd1, 32'h102, 0, 0, r); check_eq("tp_lh", r, 32'hFFFF_DEAD);
    access(1, 0, 3'd0, 32'h101, 32'h55, 1, r);
    access(0, 1, 3'd2, 32'h100, 0, 0, r); check_eq("tp_lw_after_sb", r, 32'hDEAD_55EF);
    access(1, 0, 3'd2, 32'h400, 32'h1234_5678, 2, r);
    access(0, 1, 3'd2, 32'h400, 0, 1, r); check_eq("tp_lw_nwa", r, 32'h1234_5678);
    access(0, 1, 3'd2, 32'h500, 0, 0, r);
    access(0, 1, 3'd2, 32'h100, 0, 1, r); check_eq("tp_lw_evicted", r, 32'hDEAD_55EF);

    // Reset while a fill is outstanding.
    @(posedge clk); #1;
    write_en_in = 1'b0; read_en_in = 1'b1; func_3_in = 3'd2; addr_in = 32'h7F00;
    @(negedge clk); #1;
    check_eq("abort_entry_stall", {31'd0, stall_out}, 32'd1);
    @(posedge clk); #1;
    check_eq("abort_req_up", {31'd0, mem_req_out}, 32'd1);
    rst = 1'b1; read_en_in = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < SETS; i++) mv[i] = 1'b0;
`ifdef CACHE_STATS_EN
    m_hits = 0; m_misses = 0;
`endif
    @(negedge clk);
    check_eq("abort_req_next", {31'd0, mem_req_out}, 32'd0);
    access(0, 1, 3'd2, 32'h100, 0, 1, r); check_eq("abort_reload", r, 32'hDEAD_55EF);

    for (int i = 0; i < 250; i++) begin
      op = $urandom_range(0, 9);
      a  = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      if (op < 2)
        access(0, 0, 3'd2, a, 0, 0, r);
      else if (op < 5)
        access(1, ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 2)), a, $urandom, $urandom_range(0, 3), r);
      else
        access(0, 1, ld_f3[$urandom_range(0, 7)], a, 0, $urandom_range(0, 3), r);
    end

`ifdef CACHE_STATS_EN
    @(negedge clk);
    check_eq("stat_hits", hit_count_out, m_hits);
    check_eq("stat_misses", miss_count_out, m_misses);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
